// File: rtl/pipe_hold_ctrl.sv
// pipe_hold_ctrl: pipeline hold/redirect controller.
// Merges stall requests from execute, the interrupt controller, the bus
// arbiter and the debugger into one hold level. It forwards branch/interrupt
// redirects to the PC and inserts FLUSH_CYCLES bubble cycles after each one.
// Optional bus-hold watchdog: define PIPE_HOLD_WDT_EN to build it. Without
// that macro, timeout_o is tied low.
// Handshake note: there is no valid/ready flow here. Every request input is
// level-sensitive and is honoured in the same cycle it is high.
// The FSM state is visible on flush_busy_o (1 = FLUSH, 0 = IDLE).
module pipe_hold_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int WDT_LIMIT    = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_flag_i,
    input  logic [31:0] jump_addr_i,
    input  logic        hold_flag_ex_i,
    input  logic        hold_flag_clint_i,
    input  logic        int_assert_i,
    input  logic [31:0] int_addr_i,
    input  logic        hold_flag_rib_i,
    input  logic        jtag_halt_flag_i,
    output logic [2:0]  hold_flag_o,
    output logic        jump_flag_o,
    output logic [31:0] jump_addr_o,
    output logic        flush_busy_o,
    output logic [31:0] stall_cnt_o,
    output logic        timeout_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam logic [2:0] HOLD_NONE = 3'd0;
    localparam logic [2:0] HOLD_PC   = 3'd1;
    localparam logic [2:0] HOLD_IF   = 3'd2;
    localparam logic [2:0] HOLD_ID   = 3'd3;

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

    // Reject out-of-range configurations at elaboration.
    if (FLUSH_CYCLES < 0 || FLUSH_CYCLES > 7 || WDT_LIMIT < 1 || WDT_LIMIT > 65535) begin : g_bad_param
        $error("pipe_hold_ctrl: FLUSH_CYCLES must be 0..7 and WDT_LIMIT 1..65535");
    end

    state_t     state;
    logic [2:0] flush_cnt;
    logic [2:0] req_level;
    logic [2:0] fsm_level;
    logic       redirect;

    // Request level: an ID-stage hold for execute-side events, a PC hold for bus/debug.
    always_comb begin
        req_level = HOLD_NONE;
        if (hold_flag_ex_i | hold_flag_clint_i | jump_flag_i | int_assert_i) begin
            req_level = HOLD_ID;
        end else if (hold_flag_rib_i | jtag_halt_flag_i) begin
            req_level = HOLD_PC;
        end
    end

    assign redirect    = jump_flag_i | int_assert_i;
    assign fsm_level   = (state == FLUSH) ? HOLD_IF : HOLD_NONE;
    assign hold_flag_o = (req_level > fsm_level) ? req_level : fsm_level;
    assign jump_flag_o = redirect;

    // Redirect target: the interrupt wins over a branch taken in the same cycle.
    always_comb begin
        jump_addr_o = 32'd0;
        if (int_assert_i) begin
            jump_addr_o = int_addr_i;
        end else if (jump_flag_i) begin
            jump_addr_o = jump_addr_i;
        end
    end

    assign flush_busy_o = (state == FLUSH);

    // Flush sequencer. A new redirect during FLUSH restarts the count rather than extending it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            flush_cnt <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (redirect && (FLUSH_CYCLES > 0)) begin
                        state     <= FLUSH;
                        flush_cnt <= FLUSH_LOAD;
                    end
                end
                FLUSH: begin
                    if (redirect) begin
                        flush_cnt <= FLUSH_LOAD;
                    end else if (flush_cnt <= 3'd1) begin
                        state     <= IDLE;
                        flush_cnt <= 3'd0;
                    end else begin
                        flush_cnt <= flush_cnt - 3'd1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    flush_cnt <= 3'd0;
                end
            endcase
        end
    end

    // Count every cycle in which any pipeline stage is held. The counter wraps naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_o <= 32'd0;
        end else if (hold_flag_o != HOLD_NONE) begin
            stall_cnt_o <= stall_cnt_o + 32'd1;
        end
    end

`ifdef PIPE_HOLD_WDT_EN
    localparam logic [15:0] WDT_MAX = 16'(WDT_LIMIT);

    logic [15:0] wdt_cnt;
    logic        timeout_q;

    // Watchdog: count consecutive cycles the bus is lost, saturate at the limit, and latch timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            wdt_cnt   <= 16'd0;
            timeout_q <= 1'b0;
        end else if (!hold_flag_rib_i) begin
            wdt_cnt <= 16'd0;
        end else if (wdt_cnt != WDT_MAX) begin
            wdt_cnt <= wdt_cnt + 16'd1;
            if (wdt_cnt + 16'd1 == WDT_MAX) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_hold_ctrl.sv
// Bench for pipe_hold_ctrl with FLUSH_CYCLES=2 and WDT_LIMIT=4.
// The watchdog checks adapt to whether PIPE_HOLD_WDT_EN is defined.
module tb_pipe_hold_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        jump_flag_i = 1'b0;
    logic [31:0] jump_addr_i = 32'd0;
    logic        hold_flag_ex_i = 1'b0;
    logic        hold_flag_clint_i = 1'b0;
    logic        int_assert_i = 1'b0;
    logic [31:0] int_addr_i = 32'd0;
    logic        hold_flag_rib_i = 1'b0;
    logic        jtag_halt_flag_i = 1'b0;
    logic [2:0]  hold_flag_o;
    logic        jump_flag_o;
    logic [31:0] jump_addr_o;
    logic        flush_busy_o;
    logic [31:0] stall_cnt_o;
    logic        timeout_o;

    pipe_hold_ctrl #(.FLUSH_CYCLES(2), .WDT_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
        .hold_flag_ex_i(hold_flag_ex_i), .hold_flag_clint_i(hold_flag_clint_i),
        .int_assert_i(int_assert_i), .int_addr_i(int_addr_i),
        .hold_flag_rib_i(hold_flag_rib_i), .jtag_halt_flag_i(jtag_halt_flag_i),
        .hold_flag_o(hold_flag_o), .jump_flag_o(jump_flag_o), .jump_addr_o(jump_addr_o),
        .flush_busy_o(flush_busy_o), .stall_cnt_o(stall_cnt_o), .timeout_o(timeout_o)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL sim_timeout: bench did not finish");
        $fatal(1);
    end

    typedef struct {
        logic        rst;
        logic        jf;
        logic [31:0] ja;
        logic        ex;
        logic        cl;
        logic        it;
        logic [31:0] ia;
        logic        rib;
        logic        jtag;
        logic [2:0]  eh;
        logic        ejf;
        logic [31:0] eja;
    } vec_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [35:0] exp_q[$];
    logic [31:0] m_stall = 32'd0;
    logic        exp_to  = 1'b0;
    vec_t        tbl[12];

    function automatic vec_t mk(input logic r, input logic jf, input logic [31:0] ja,
                                input logic ex, input logic cl, input logic it,
                                input logic [31:0] ia, input logic rib, input logic jtag,
                                input logic [2:0] eh, input logic ejf, input logic [31:0] eja);
        vec_t v;
        v.rst = r; v.jf = jf; v.ja = ja; v.ex = ex; v.cl = cl; v.it = it;
        v.ia = ia; v.rib = rib; v.jtag = jtag; v.eh = eh; v.ejf = ejf; v.eja = eja;
        return v;
    endfunction

    function automatic vec_t idle_v(input logic r, input logic [2:0] eh);
        return mk(r, 0, 0, 0, 0, 0, 0, 0, 0, eh, 0, 0);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // driver: apply one vector at the falling edge
    task automatic drive(input vec_t v);
        @(negedge clk);
        rst               = v.rst;
        jump_flag_i       = v.jf;
        jump_addr_i       = v.ja;
        hold_flag_ex_i    = v.ex;
        hold_flag_clint_i = v.cl;
        int_assert_i      = v.it;
        int_addr_i        = v.ia;
        hold_flag_rib_i   = v.rib;
        jtag_halt_flag_i  = v.jtag;
    endtask

    // scoreboard: push the expectation with the stimulus, pop and compare once outputs settle
    task automatic run_vec(input string name, input vec_t v, input logic e_busy);
        logic [35:0] e;
        drive(v);
        exp_q.push_back({v.eh, v.ejf, v.eja});
        #1;
        e = exp_q.pop_front();
        chk({name, "/hold"}, 32'(hold_flag_o), 32'(e[35:33]));
        chk({name, "/jflag"}, 32'(jump_flag_o), 32'(e[32]));
        chk({name, "/jaddr"}, jump_addr_o, e[31:0]);
        chk({name, "/busy"}, 32'(flush_busy_o), 32'(e_busy));
        chk({name, "/stall"}, stall_cnt_o, m_stall);
        chk({name, "/timeout"}, 32'(timeout_o), 32'(exp_to));
        if (v.rst) m_stall = 32'd0;
        else if (v.eh != 3'd0) m_stall = m_stall + 32'd1;
    endtask

    initial begin
        // table: {rst, jf, ja, ex, clint, int, ia, rib, jtag, exp hold, exp jflag, exp jaddr}
        tbl[0]  = mk(0, 0, 32'h0,    0, 0, 0, 32'h0,    0, 0, 3'd0, 0, 32'h0);
        tbl[1]  = mk(0, 0, 32'h0,    1, 0, 0, 32'h0,    0, 0, 3'd3, 0, 32'h0);
        tbl[2]  = mk(0, 0, 32'h0,    0, 1, 0, 32'h0,    0, 0, 3'd3, 0, 32'h0);
        tbl[3]  = mk(0, 0, 32'h0,    0, 0, 0, 32'h0,    1, 0, 3'd1, 0, 32'h0);
        tbl[4]  = mk(0, 0, 32'h0,    0, 0, 0, 32'h0,    0, 1, 3'd1, 0, 32'h0);
        tbl[5]  = mk(0, 0, 32'h0,    1, 0, 0, 32'h0,    1, 0, 3'd3, 0, 32'h0);
        tbl[6]  = mk(0, 0, 32'h0,    0, 0, 0, 32'h0,    1, 1, 3'd1, 0, 32'h0);
        tbl[7]  = mk(0, 1, 32'h100,  0, 0, 0, 32'h0,    0, 0, 3'd3, 1, 32'h100);
        tbl[8]  = mk(0, 0, 32'h0,    0, 0, 1, 32'h80,   0, 0, 3'd3, 1, 32'h80);
        tbl[9]  = mk(0, 1, 32'h100,  0, 0, 1, 32'h80,   0, 0, 3'd3, 1, 32'h80);
        tbl[10] = mk(0, 0, 32'h1234, 1, 0, 0, 32'h0,    0, 0, 3'd3, 0, 32'h0);
        tbl[11] = mk(0, 0, 32'h0,    0, 0, 0, 32'hdead, 1, 0, 3'd1, 0, 32'h0);

        // reset state, and combinational paths while reset is held
        run_vec("rst_idle", idle_v(1, 3'd0), 1'b0);
        run_vec("rst_ex", mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 3'd3, 0, 0), 1'b0);
        run_vec("rst_jump", mk(1, 1, 32'h100, 0, 0, 0, 0, 0, 0, 3'd3, 1, 32'h100), 1'b0);
        run_vec("rst_release", idle_v(0, 3'd0), 1'b0);

        // table, with the flush tail drained after any redirect
        for (int i = 0; i < 12; i++) begin
            run_vec($sformatf("row%0d", i), tbl[i], 1'b0);
            if (tbl[i].ejf) begin
                run_vec($sformatf("row%0d_fl1", i), idle_v(0, 3'd2), 1'b1);
                run_vec($sformatf("row%0d_fl2", i), idle_v(0, 3'd2), 1'b1);
            end
            run_vec($sformatf("row%0d_end", i), idle_v(0, 3'd0), 1'b0);
        end

        // second jump one cycle into FLUSH restarts the bubble count
        run_vec("rj_j1", mk(0, 1, 32'h100, 0, 0, 0, 0, 0, 0, 3'd3, 1, 32'h100), 1'b0);
        run_vec("rj_j2", mk(0, 1, 32'h140, 0, 0, 0, 0, 0, 0, 3'd3, 1, 32'h140), 1'b1);
        run_vec("rj_f1", idle_v(0, 3'd2), 1'b1);
        run_vec("rj_f2", idle_v(0, 3'd2), 1'b1);
        run_vec("rj_end", idle_v(0, 3'd0), 1'b0);

        // five stalled cycles from a cleared counter
        run_vec("st_rst", idle_v(1, 3'd0), 1'b0);
        for (int i = 0; i < 5; i++) begin
            run_vec($sformatf("st_ex%0d", i), mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 3'd3, 0, 0), 1'b0);
        end
        run_vec("st_done", idle_v(0, 3'd0), 1'b0);
        chk("stall_eq_5", stall_cnt_o, 32'd5);

        // reset in the middle of FLUSH aborts it
        run_vec("rf_jump", mk(0, 1, 32'h200, 0, 0, 0, 0, 0, 0, 3'd3, 1, 32'h200), 1'b0);
        run_vec("rf_flush", idle_v(0, 3'd2), 1'b1);
        run_vec("rf_rst", idle_v(1, 3'd2), 1'b1);
        run_vec("rf_after", idle_v(0, 3'd0), 1'b0);
        chk("rf_stall_zero", stall_cnt_o, 32'd0);

        // watchdog: two broken runs of 3, then an unbroken run of 4
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 3; i++) begin
                run_vec($sformatf("wd_run%0d_%0d", r, i), mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 3'd1, 0, 0), 1'b0);
            end
            run_vec($sformatf("wd_gap%0d", r), idle_v(0, 3'd0), 1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            run_vec($sformatf("wd_full%0d", i), mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 3'd1, 0, 0), 1'b0);
        end
`ifdef PIPE_HOLD_WDT_EN
        exp_to = 1'b1;
`endif
        run_vec("wd_fired", idle_v(0, 3'd0), 1'b0);
        run_vec("wd_sticky", idle_v(0, 3'd0), 1'b0);
        run_vec("wd_rst", idle_v(1, 3'd0), 1'b0);
        exp_to = 1'b0;
        run_vec("wd_cleared", idle_v(0, 3'd0), 1'b0);

        // final report
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_hold_ctrl.md
PIPE_HOLD_CTRL -- requirements
Module: pipe_hold_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 1, giving post-redirect bubble cycles after the redirect cycle; legal range 0..7.
REQ-002 SHALL have parameter WDT_LIMIT, default 255, giving the consecutive bus-hold cycles before timeout; legal range 1..65535.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port jump_flag_i, input, 1, the execute-stage branch/jump taken request.
REQ-006 SHALL have port jump_addr_i, input, 32, the execute-stage jump target.
REQ-007 SHALL have port hold_flag_ex_i, input, 1, the execute multi-cycle op (mul/div) stall request.
REQ-008 SHALL have port hold_flag_clint_i, input, 1, the interrupt-controller CSR sequencing stall request.
REQ-009 SHALL have port int_assert_i, input, 1, the interrupt redirect request.
REQ-010 SHALL have port int_addr_i, input, 32, the interrupt redirect target.
REQ-011 SHALL have port hold_flag_rib_i, input, 1, the bus lost to another master stall request.
REQ-012 SHALL have port jtag_halt_flag_i, input, 1, the debugger halt request.
REQ-013 SHALL have port hold_flag_o, output, 3, the pipeline hold level: 0 none, 1 PC, 2 IF, 3 ID.
REQ-014 SHALL have port jump_flag_o, output, 1, the PC redirect strobe.
REQ-015 SHALL have port jump_addr_o, output, 32, the PC redirect target.
REQ-016 SHALL have port flush_busy_o, output, 1, high while the FSM is in FLUSH.
REQ-017 SHALL have port stall_cnt_o, output, 32, the cycles with hold_flag_o != 0.
REQ-018 SHALL have port timeout_o, output, 1, the sticky bus-hold watchdog flag.

Function
REQ-019 SHALL compute request level combinationally: ex, clint, jump, int -> 3; rib, jtag -> 1; none -> 0.
REQ-020 SHALL drive hold_flag_o = max(request level, FSM level); FSM level is 2 in FLUSH and 0 in IDLE; zero latency from any request input.
REQ-021 SHALL drive jump_flag_o = jump_flag_i | int_assert_i, combinationally in the same cycle.
REQ-022 SHALL select jump_addr_o = int_addr_i when int_assert_i=1, else jump_addr_i when jump_flag_i=1, else 0.
REQ-023 SHALL implement FSM states IDLE and FLUSH.
REQ-024 SHALL transition IDLE -> FLUSH on a redirect (jump_flag_o=1) when FLUSH_CYCLES>0, loading flush counter = FLUSH_CYCLES.
REQ-025 SHALL decrement the counter each FLUSH cycle and return to IDLE on the cycle it reads 1.
REQ-026 SHALL reload the counter to FLUSH_CYCLES and remain in FLUSH on a new redirect in FLUSH (restart, no accumulation).
REQ-027 SHALL, with FLUSH_CYCLES=0, never leave IDLE and keep flush_busy_o at 0.
REQ-028 SHALL, with simultaneous jump_flag_i and int_assert_i, take the interrupt target and run one flush sequence.
REQ-029 SHALL increment stall_cnt_o by 1 each cycle hold_flag_o != 0 and wrap 0xFFFFFFFF -> 0.
REQ-030 SHALL register all FSM, counter and flag state; hold_flag_o, jump_flag_o and jump_addr_o have no added latency.

Reset
REQ-031 SHALL, on rst=1 at a clock edge, force FSM=IDLE, flush counter=0, stall_cnt_o=0, timeout_o=0, watchdog count=0, aborting any flush in progress.
REQ-032 SHALL keep combinational outputs following inputs during reset; with all inputs low they read hold_flag_o=0, jump_flag_o=0, jump_addr_o=0.

Configuration
REQ-033 SHALL provide macro PIPE_HOLD_WDT_EN; when defined, a 16-bit counter counts consecutive hold_flag_rib_i=1 cycles and clears on any 0 cycle.
REQ-034 SHALL, with PIPE_HOLD_WDT_EN, set timeout_o=1 on the edge the count reaches WDT_LIMIT, saturate the count, and hold timeout_o until rst.
REQ-035 SHALL, without PIPE_HOLD_WDT_EN, tie timeout_o to 0 and instantiate no watchdog logic.

Verification
REQ-036 SHALL cover: jump_flag_i=1, addr 0x100 for 1 cycle, FLUSH_CYCLES=2 -> jump_flag_o=1, addr 0x100, hold 3 that cycle; hold 2 for the next 2 cycles; then 0.
REQ-037 SHALL cover: jump_flag_i and int_assert_i together (0x100 / 0x80) -> jump_addr_o=0x80, single flush sequence.
REQ-038 SHALL cover: second jump one cycle into FLUSH (FLUSH_CYCLES=2) -> flush_busy_o stays high 2 cycles after the second jump.
REQ-039 SHALL cover: hold_flag_rib_i=1 and hold_flag_ex_i=1 together -> hold_flag_o=3; rib alone -> 1; 5 stalled cycles -> stall_cnt_o=5.
REQ-040 SHALL cover: PIPE_HOLD_WDT_EN defined, WDT_LIMIT=4, rib high 4 cycles -> timeout_o=1 after the 4th edge; rib high 3 cycles, low 1, high 3 -> timeout_o stays 0.
REQ-041 SHALL cover: rst=1 in the middle of FLUSH -> next cycle flush_busy_o=0, stall_cnt_o=0, hold_flag_o=0 with inputs idle.
